lamp_safety_driver: RTL and testbench

//  Downstream of traffic_light_controller: converts the four 2-bit direction codes into per-direction
//  R/Y/G lamp drives. Filters glitches on the combinational codes; monitors for conflicting or illegal

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/code_debounce.sv | 41 ++++
 rtl/lamp_safety_driver.sv | 138 +++++++++++++
 tb/tb_lamp_safety_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-light encodings: direction codes, lamp drives, fault types
// and safety FSM states, plus the code-to-lamp decode.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MULTI   = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  // An illegal code falls back to red; the conflict path overrides it anyway.
  function automatic logic [2:0] decode_lamp(input logic [1:0] code);
    logic [2:0] lamp;
    case (code)
      LIGHT_RED:    lamp = LAMP_RED;
      LIGHT_YELLOW: lamp = LAMP_YELLOW;
      LIGHT_GREEN:  lamp = LAMP_GREEN;
      default:      lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/code_debounce.sv
// Glitch filter for one 2-bit direction code: a new value must be seen
// unchanged for STABLE_CYCLES edges before it is committed to filt.
module code_debounce
  import traffic_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  output logic [1:0] filt
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [1:0]    smp_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    filt_r;

  // Sample, count consecutive matches, commit once the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_r  <= LIGHT_RED;
      cnt_r  <= '0;
      filt_r <= LIGHT_RED;
    end else begin
      smp_r <= dir;
      if (dir != smp_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        filt_r <= smp_r;
      end
    end
  end

  assign filt = filt_r;

endmodule

// File: rtl/lamp_safety_driver.sv
// Converts four filtered direction codes into R/Y/G lamp drives, forcing red
// on any conflict and latching a flashing-red fault if the conflict persists.
module lamp_safety_driver
  import traffic_pkg::*;
#(
  parameter int STABLE_CYCLES   = 4,
  parameter int CONFLICT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic [1:0] dir_n,
  input  logic [1:0] dir_e,
  input  logic [1:0] dir_s,
  input  logic [1:0] dir_w,
  input  logic       fault_clr,
  output logic [2:0] lamp_n,
  output logic [2:0] lamp_e,
  output logic [2:0] lamp_s,
  output logic [2:0] lamp_w,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int PW = $clog2(CONFLICT_CYCLES + 1);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(CONFLICT_CYCLES - 1);

  logic [1:0]    filt_n_s, filt_e_s, filt_s_s, filt_w_s;
  logic [2:0]    green_cnt_s;
  logic          multi_s, illegal_s, conflict_s;
  logic [1:0]    type_s;
  logic [1:0]    state_r;
  logic [PW-1:0] pcnt_r;
  logic          fault_r;
  logic [1:0]    code_r;
  logic          flash_r;

  code_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_n (.clk(clk), .rst(rst), .dir(dir_n), .filt(filt_n_s));
  code_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_e (.clk(clk), .rst(rst), .dir(dir_e), .filt(filt_e_s));
  code_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_s (.clk(clk), .rst(rst), .dir(dir_s), .filt(filt_s_s));
  code_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_w (.clk(clk), .rst(rst), .dir(dir_w), .filt(filt_w_s));

  // Conflict classification on the filtered codes.
  always_comb begin
    green_cnt_s = {2'b00, filt_n_s == LIGHT_GREEN} + {2'b00, filt_e_s == LIGHT_GREEN}
                + {2'b00, filt_s_s == LIGHT_GREEN} + {2'b00, filt_w_s == LIGHT_GREEN};
    multi_s     = (green_cnt_s > 3'd1);
    illegal_s   = (filt_n_s == LIGHT_ILLEGAL) || (filt_e_s == LIGHT_ILLEGAL)
               || (filt_s_s == LIGHT_ILLEGAL) || (filt_w_s == LIGHT_ILLEGAL);
    conflict_s  = multi_s || illegal_s;
    type_s      = (multi_s ? FAULT_MULTI : FAULT_NONE) | (illegal_s ? FAULT_ILLEGAL : FAULT_NONE);
  end

  // Safety FSM: persistence check, fault latch, flash toggle and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_NORMAL;
      pcnt_r  <= '0;
      fault_r <= 1'b0;
      code_r  <= FAULT_NONE;
      flash_r <= 1'b1;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (conflict_s && (CONFLICT_CYCLES <= 1)) begin
            state_r <= ST_FAULT;
            fault_r <= 1'b1;
            code_r  <= type_s;
            flash_r <= 1'b1;
            pcnt_r  <= '0;
          end else if (conflict_s) begin
            state_r <= ST_PENDING;
            pcnt_r  <= PCNT_ONE;
          end else begin
            pcnt_r  <= '0;
          end
        end
        ST_PENDING: begin
          if (!conflict_s) begin
            state_r <= ST_NORMAL;
            pcnt_r  <= '0;
          end else if (pcnt_r >= PCNT_LAST) begin
            state_r <= ST_FAULT;
            fault_r <= 1'b1;
            code_r  <= type_s;
            flash_r <= 1'b1;
            pcnt_r  <= '0;
          end else begin
            pcnt_r  <= pcnt_r + PCNT_ONE;
          end
        end
        ST_FAULT: begin
          if (fault_clr && !conflict_s) begin
            state_r <= ST_NORMAL;
            fault_r <= 1'b0;
            code_r  <= FAULT_NONE;
            flash_r <= 1'b1;
          end else begin
            code_r  <= code_r | type_s;
            flash_r <= tick_1s ? ~flash_r : flash_r;
          end
        end
        default: begin
          state_r <= ST_NORMAL;
          pcnt_r  <= '0;
          fault_r <= 1'b0;
          code_r  <= FAULT_NONE;
          flash_r <= 1'b1;
        end
      endcase
    end
  end

  // Lamp mux: flashing red in fault, steady red on conflict, else decoded codes.
  always_comb begin
    if (state_r == ST_FAULT) begin
      lamp_n = {flash_r, 2'b00};
      lamp_e = {flash_r, 2'b00};
      lamp_s = {flash_r, 2'b00};
      lamp_w = {flash_r, 2'b00};
    end else if (conflict_s) begin
      lamp_n = LAMP_RED;
      lamp_e = LAMP_RED;
      lamp_s = LAMP_RED;
      lamp_w = LAMP_RED;
    end else begin
      lamp_n = decode_lamp(filt_n_s);
      lamp_e = decode_lamp(filt_e_s);
      lamp_s = decode_lamp(filt_s_s);
      lamp_w = decode_lamp(filt_w_s);
    end
  end

  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule

// File: tb/tb_lamp_safety_driver.sv
// Directed bench for lamp_safety_driver with STABLE_CYCLES=4, CONFLICT_CYCLES=2.
module tb_lamp_safety_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic [1:0] dir_n = 2'b01, dir_e = 2'b01, dir_s = 2'b01, dir_w = 2'b01;
  logic       fault_clr = 1'b0;
  logic [2:0] lamp_n, lamp_e, lamp_s, lamp_w;
  logic       fault;
  logic [1:0] fault_code;
  int total = 0;
  int bad = 0;

  lamp_safety_driver #(.STABLE_CYCLES(4), .CONFLICT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .dir_n(dir_n), .dir_e(dir_e), .dir_s(dir_s), .dir_w(dir_w),
    .fault_clr(fault_clr),
    .lamp_n(lamp_n), .lamp_e(lamp_e), .lamp_s(lamp_s), .lamp_w(lamp_w),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(3);
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w} !== 12'b100_100_100_100) begin
      bad++; $display("FAIL reset_lamps got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w}, 12'b100_100_100_100);
    end
    total++;
    if ({fault, fault_code} !== 3'b000) begin
      bad++; $display("FAIL reset_fault got=%b want=%b", {fault, fault_code}, 3'b000);
    end
    dir_n = 2'b00; dir_e = 2'b00; dir_s = 2'b00; dir_w = 2'b00;
    rst = 1'b0;
    step(1);
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w, fault, fault_code} !== 15'b100_100_100_100_000) begin
      bad++; $display("FAIL reset_release got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w, fault, fault_code}, 15'b100_100_100_100_000);
    end
  endtask

  task automatic test_commit();
    dir_n = 2'b10;
    step(4);
    total++;
    if (lamp_n !== 3'b100) begin
      bad++; $display("FAIL commit_k3 got=%b want=%b", lamp_n, 3'b100);
    end
    step(1);
    total++;
    if (lamp_n !== 3'b001) begin
      bad++; $display("FAIL commit_k4 got=%b want=%b", lamp_n, 3'b001);
    end
    dir_n = 2'b00; dir_e = 2'b01;
    step(5);
    total++;
    if ({lamp_n, lamp_e} !== 6'b100_010) begin
      bad++; $display("FAIL commit_yellow got=%b want=%b", {lamp_n, lamp_e}, 6'b100_010);
    end
    dir_e = 2'b00;
    step(5);
    total++;
    if (lamp_e !== 3'b100) begin
      bad++; $display("FAIL commit_back_red got=%b want=%b", lamp_e, 3'b100);
    end
  endtask

  task automatic test_glitch();
    dir_n = 2'b10;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) dir_n = 2'b00;
      step(1);
      total++;
      if (lamp_n !== 3'b100) begin
        bad++; $display("FAIL glitch_cyc%0d got=%b want=%b", i, lamp_n, 3'b100);
      end
    end
  endtask

  task automatic test_multi_green();
    dir_n = 2'b10; dir_e = 2'b10;
    step(5);
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w, fault} !== 13'b100_100_100_100_0) begin
      bad++; $display("FAIL multi_red_now got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w, fault}, 13'b100_100_100_100_0);
    end
    step(1);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL multi_pending got=%b want=%b", fault, 1'b0);
    end
    step(1);
    total++;
    if ({fault, fault_code, lamp_n} !== 6'b1_01_100) begin
      bad++; $display("FAIL multi_fault got=%b want=%b", {fault, fault_code, lamp_n}, 6'b1_01_100);
    end
    tick_1s = 1'b1; step(1); tick_1s = 1'b0;
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w} !== 12'b000_000_000_000) begin
      bad++; $display("FAIL multi_flash_off got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w}, 12'b0);
    end
    step(2);
    tick_1s = 1'b1; step(1); tick_1s = 1'b0;
    total++;
    if ({lamp_n, lamp_w} !== 6'b100_100) begin
      bad++; $display("FAIL multi_flash_on got=%b want=%b", {lamp_n, lamp_w}, 6'b100_100);
    end
  endtask

  task automatic test_clear();
    fault_clr = 1'b1;
    step(2);
    fault_clr = 1'b0;
    total++;
    if ({fault, fault_code} !== 3'b1_01) begin
      bad++; $display("FAIL clear_ignored got=%b want=%b", {fault, fault_code}, 3'b1_01);
    end
    dir_n = 2'b00; dir_e = 2'b00; dir_s = 2'b10;
    step(5);
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL clear_held got=%b want=%b", fault, 1'b1);
    end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    total++;
    if ({fault, fault_code, lamp_n, lamp_e, lamp_s, lamp_w} !== 15'b0_00_100_100_001_100) begin
      bad++; $display("FAIL clear_done got=%b want=%b", {fault, fault_code, lamp_n, lamp_e, lamp_s, lamp_w}, 15'b0_00_100_100_001_100);
    end
  endtask

  task automatic test_illegal();
    dir_w = 2'b11;
    step(4);
    total++;
    if (lamp_s !== 3'b001) begin
      bad++; $display("FAIL illegal_before got=%b want=%b", lamp_s, 3'b001);
    end
    step(1);
    total++;
    if ({lamp_s, fault} !== 4'b100_0) begin
      bad++; $display("FAIL illegal_red_now got=%b want=%b", {lamp_s, fault}, 4'b100_0);
    end
    step(1);
    tick_1s = 1'b1; step(1); tick_1s = 1'b0;
    total++;
    if ({fault, fault_code, lamp_s, lamp_w} !== 9'b1_10_100_100) begin
      bad++; $display("FAIL illegal_fault_entry got=%b want=%b", {fault, fault_code, lamp_s, lamp_w}, 9'b1_10_100_100);
    end
    total++;
    if (((lamp_n | lamp_e | lamp_s | lamp_w) & 3'b011) !== 3'b000) begin
      bad++; $display("FAIL illegal_yg_off got=%b want=%b", (lamp_n | lamp_e | lamp_s | lamp_w), 3'b100);
    end
    dir_n = 2'b10;
    step(6);
    total++;
    if (fault_code !== 2'b11) begin
      bad++; $display("FAIL illegal_code_or got=%b want=%b", fault_code, 2'b11);
    end
  endtask

  task automatic test_reset_mid_fault();
    tick_1s = 1'b1; step(1); tick_1s = 1'b0;
    total++;
    if (lamp_n !== 3'b000) begin
      bad++; $display("FAIL rstmid_flash_off got=%b want=%b", lamp_n, 3'b000);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w, fault, fault_code} !== 15'b100_100_100_100_000) begin
      bad++; $display("FAIL rstmid_async got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w, fault, fault_code}, 15'b100_100_100_100_000);
    end
    dir_n = 2'b00; dir_e = 2'b00; dir_s = 2'b00; dir_w = 2'b00;
    step(2);
    rst = 1'b0;
    step(6);
    total++;
    if ({lamp_n, lamp_e, lamp_s, lamp_w, fault} !== 13'b100_100_100_100_0) begin
      bad++; $display("FAIL rstmid_after got=%b want=%b", {lamp_n, lamp_e, lamp_s, lamp_w, fault}, 13'b100_100_100_100_0);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_glitch();
    test_multi_green();
    test_clear();
    test_illegal();
    test_reset_mid_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
